// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and helpers for the MEM-stage load/store unit.
//   lsu_op_t     - memory operation carried down from the execute stage
//   SZ_B/H/W     - data bus transfer size encodings
//   lsu_state_t  - MEM-stage access FSM states
//   lsu_is_load / lsu_is_store / lsu_size / lsu_wdata / lsu_wstrb
//                - decode helpers for the bus request fields
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LBU  = 4'd2,
        LSU_LH   = 4'd3,
        LSU_LHU  = 4'd4,
        LSU_LW   = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic lsu_is_load(lsu_op_t op);
        return (op == LSU_LB) || (op == LSU_LBU) || (op == LSU_LH) ||
               (op == LSU_LHU) || (op == LSU_LW);
    endfunction

    function automatic logic lsu_is_store(lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic [1:0] lsu_size(lsu_op_t op);
        logic [1:0] sz;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: sz = SZ_B;
            LSU_LH, LSU_LHU, LSU_SH: sz = SZ_H;
            default:                 sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Store data is replicated across all lanes so the strobes alone pick
    // the bytes that land in memory.
    function automatic logic [31:0] lsu_wdata(lsu_op_t op, logic [31:0] d);
        logic [31:0] w;
        case (op)
            LSU_SB:  w = {4{d[7:0]}};
            LSU_SH:  w = {2{d[15:0]}};
            LSU_SW:  w = d;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] lsu_wstrb(lsu_op_t op, logic [1:0] a);
        logic [3:0] s;
        case (op)
            LSU_SB:  s = 4'b0001 << a;
            LSU_SH:  s = a[1] ? 4'b1100 : 4'b0011;
            LSU_SW:  s = 4'hF;
            default: s = 4'h0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: SRAM-like data bus between the load/store unit and memory.
//   data_req/wr/size/addr/wdata/wstrb - request side, driven by the master
//   data_addr_ok  - request accepted this cycle
//   data_data_ok  - read data valid / write acknowledged this cycle
//   data_rdata    - raw 32-bit read data
interface mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_lsu_load_align.sv
// mem_lsu_load_align: combinational load data aligner/extender.
//   op_i      - load operation (non-load ops pass rdata through)
//   addr_lo_i - byte offset of the access within the word
//   rdata_i   - raw 32-bit word from the bus
//   data_o    - aligned, sign/zero-extended result
module mem_lsu_load_align
    import mem_lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rdata_i >> {addr_lo_i, 3'b000});
    assign half_v = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});

    always_comb begin
        case (op_i)
            LSU_LB:  data_o = {{24{byte_v[7]}}, byte_v};
            LSU_LBU: data_o = {24'h0, byte_v};
            LSU_LH:  data_o = {{16{half_v[15]}}, half_v};
            LSU_LHU: data_o = {16'h0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Captures the execute-stage memory op when the stage advances, issues it on
// the SRAM-like data bus, stalls the pipeline until it completes and then
// presents aligned load data for writeback/bypass. A flush that arrives while
// a request is outstanding cannot withdraw it; the access is tracked to
// completion with `cancel` set and its result discarded.
//   clk, resetn         - clock, asynchronous active-low reset
//   MEM_Flush           - squash the op in this stage
//   MEM_Wr              - stage advance enable
//   EXE_Valid/LsuOp/Addr/StoreData/HasExcept - incoming op from execute
//   bus (master)        - data bus request/response
//   MEM_LsuStall        - hold earlier stages while the access is pending
//   MEM_LoadData        - aligned, extended load result (held after data_ok)
//   MEM_LoadValid       - MEM_LoadData valid for a completed load
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit KSEG_STRIP = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             MEM_Flush,
    input  logic             MEM_Wr,
    input  logic             EXE_Valid,
    input  lsu_op_t          EXE_LsuOp,
    input  logic [31:0]      EXE_Addr,
    input  logic [31:0]      EXE_StoreData,
    input  logic             EXE_HasExcept,
    mem_lsu_if.master        bus,
    output logic             MEM_LsuStall,
    output logic [31:0]      MEM_LoadData,
    output logic             MEM_LoadValid
);

    lsu_state_t        state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              req_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    lsu_op_t           op_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       load_data_q;

    logic              op_ok;
    logic              capture;
    logic              load_we;
    logic              kill;
    logic [31:0]       align_data;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) are unmapped windows onto the
    // low 512 MB; clearing the top three bits yields the physical address.
    function automatic logic [ADDR_W-1:0] to_phys(logic [31:0] va);
        logic [31:0] pa;
        pa = va;
        if (KSEG_STRIP && (va[31:30] == 2'b10)) begin
            pa[31:29] = 3'b000;
        end
        return ADDR_W'(pa);
    endfunction

    assign op_ok = EXE_Valid && (EXE_LsuOp != LSU_NONE) && !EXE_HasExcept;

    // An already-cancelled access or a flush this cycle both mean the
    // in-flight result must be thrown away.
    assign kill = cancel_q || MEM_Flush;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        capture  = 1'b0;
        load_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // cancel is never set in these states, so a capture here can
                // never overlap a cancelled access.
                cancel_d = 1'b0;
                if (MEM_Flush) begin
                    state_d = ST_IDLE;
                end else if (MEM_Wr) begin
                    if (op_ok) begin
                        capture = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REQ: begin
                cancel_d = kill;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d  = kill ? ST_IDLE : ST_DONE;
                        cancel_d = 1'b0;
                        load_we  = !kill;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cancel_d = kill;
                if (bus.data_data_ok) begin
                    state_d  = kill ? ST_IDLE : ST_DONE;
                    cancel_d = 1'b0;
                    load_we  = !kill;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            // Request stays up for every REQ cycle, i.e. until addr_ok.
            req_q    <= (state_d == ST_REQ);
        end
    end

    // Request fields only change on capture, so they hold steady from the
    // first req cycle through addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            op_q      <= LSU_NONE;
            addr_lo_q <= 2'd0;
        end else if (capture) begin
            wr_q      <= lsu_is_store(EXE_LsuOp);
            size_q    <= lsu_size(EXE_LsuOp);
            addr_q    <= to_phys(EXE_Addr);
            wdata_q   <= lsu_wdata(EXE_LsuOp, EXE_StoreData);
            wstrb_q   <= lsu_wstrb(EXE_LsuOp, EXE_Addr[1:0]);
            op_q      <= EXE_LsuOp;
            addr_lo_q <= EXE_Addr[1:0];
        end
    end

    mem_lsu_load_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (bus.data_rdata),
        .data_o    (align_data)
    );

    // Stores also complete with data_ok; only loads update the result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_data_q <= 32'h0;
        end else if (load_we && lsu_is_load(op_q)) begin
            load_data_q <= align_data;
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.data_wstrb = wstrb_q;

    assign MEM_LsuStall  = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !cancel_q;
    assign MEM_LoadData  = load_data_q;
    assign MEM_LoadValid = (state_q == ST_DONE) && lsu_is_load(op_q);

endmodule
